// File: rtl/synapse_fetch_ctrl.sv
// rtl/synapse_fetch_ctrl.sv - spike-driven synapse row fetch controller
//
// synapse_fetch_fifo: small circular queue holding fetched weights.
//   push/push_data write the tail, pop retires the head, head_data/empty/count
//   describe the current contents. Push and pop may coincide at any occupancy.
//
// synapse_fetch_ctrl: accepts a presynaptic spike index, reads the N_POST
// weights of that row from a fixed-latency synapse memory and streams them
// out with their postsynaptic index.
//   clk, rst_n                    : clock, synchronous active-low reset
//   i_spike_valid/i_spike_idx     : spike offer; o_spike_ready accepts it
//   o_rd_addr/o_rd_en/i_rd_data   : synapse memory read port
//   o_w_valid/i_w_ready           : weight stream handshake
//   o_w_data/o_w_post_idx/o_w_last: weight, target index, end-of-row flag
//   o_busy, o_done, o_err         : row in progress, row-complete pulse,
//                                   bad-index pulse

module synapse_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
endmodule

module synapse_fetch_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int N_PRE      = 100,
  parameter int N_POST     = 100,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          i_spike_valid,
  input  logic [((N_PRE > 1) ? $clog2(N_PRE) : 1)-1:0]  i_spike_idx,
  output logic                                          o_spike_ready,
  output logic [ADDR_WIDTH-1:0]                         o_rd_addr,
  output logic                                          o_rd_en,
  input  logic signed [DATA_WIDTH-1:0]                  i_rd_data,
  output logic                                          o_w_valid,
  input  logic                                          i_w_ready,
  output logic signed [DATA_WIDTH-1:0]                  o_w_data,
  output logic [((N_POST > 1) ? $clog2(N_POST) : 1)-1:0] o_w_post_idx,
  output logic                                          o_w_last,
  output logic                                          o_busy,
  output logic                                          o_done,
  output logic                                          o_err
);
  localparam int POST_W = (N_POST > 1) ? $clog2(N_POST) : 1;
  localparam int ENT_W  = DATA_WIDTH + POST_W + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  if (longint'(N_PRE) * longint'(N_POST) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr_width
    $error("synapse_fetch_ctrl: N_PRE*N_POST does not fit in ADDR_WIDTH");
  end
  if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_bad_fifo_depth
    $error("synapse_fetch_ctrl: FIFO_DEPTH must be at least RD_LATENCY+2");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_now;
  logic [POST_W-1:0]     p_q;
  logic                  err_q;
  logic                  done_q;

  // Tag pipeline runs alongside the memory latency so each returning word
  // knows its post index and whether it closes the row.
  logic                  tag_v_q    [RD_LATENCY];
  logic [POST_W-1:0]     tag_p_q    [RD_LATENCY];
  logic                  tag_last_q [RD_LATENCY];

  logic [ENT_W-1:0]      fifo_head;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_empty;
  logic [OCC_W-1:0]      inflight;
  logic                  accept, idx_ok, issue, p_last, pop, head_last;

  assign accept      = (state_q == S_IDLE) && i_spike_valid;
  assign idx_ok      = int'(i_spike_idx) < N_PRE;
  assign p_last      = (p_q == POST_W'(N_POST - 1));
  assign rd_addr_now = base_q + ADDR_WIDTH'(p_q);
  assign pop         = !fifo_empty && i_w_ready;
  assign head_last   = fifo_head[0];

  // Space reservation counts words still in the memory pipeline as occupied;
  // a pop in this same cycle is deliberately ignored, keeping the check
  // free of any path from i_w_ready to o_rd_en.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + OCC_W'(tag_v_q[i]);
  end

  assign issue = (state_q == S_FETCH) &&
                 ((OCC_W'(fifo_count) + inflight) < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && idx_ok)    state_d = S_FETCH;
      S_FETCH: if (issue && p_last)     state_d = S_DRAIN;
      S_DRAIN: if (pop && head_last)    state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_v_q[i]    <= 1'b0;
        tag_p_q[i]    <= '0;
        tag_last_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= accept && !idx_ok;
      done_q  <= (state_q == S_DRAIN) && (state_d == S_IDLE);
      if (accept && idx_ok) begin
        base_q <= ADDR_WIDTH'(i_spike_idx) * ADDR_WIDTH'(N_POST);
        p_q    <= '0;
      end
      if (issue) begin
        p_q    <= p_q + 1'b1;
        addr_q <= rd_addr_now;
      end
      tag_v_q[0]    <= issue;
      tag_p_q[0]    <= p_q;
      tag_last_q[0] <= p_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_p_q[i]    <= tag_p_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  synapse_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_v_q[RD_LATENCY-1]),
    .push_data ({i_rd_data, tag_p_q[RD_LATENCY-1], tag_last_q[RD_LATENCY-1]}),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign o_spike_ready = (state_q == S_IDLE);
  assign o_rd_en       = issue;
  assign o_rd_addr     = issue ? rd_addr_now : addr_q;
  assign o_w_valid     = !fifo_empty;
  assign o_w_data      = fifo_head[ENT_W-1 -: DATA_WIDTH];
  assign o_w_post_idx  = fifo_head[POST_W:1];
  assign o_w_last      = head_last;
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_err         = err_q;
endmodule

// File: tb/tb_synapse_fetch_ctrl.sv
// tb/tb_synapse_fetch_ctrl.sv - scoreboard bench for synapse_fetch_ctrl
module tb_synapse_fetch_ctrl;
  localparam int DW = 8, AW = 14, NPRE = 100, NPOST = 100, RL = 2, FD = 4;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              i_spike_valid;
  logic [6:0]        i_spike_idx;
  logic              o_spike_ready;
  logic [AW-1:0]     o_rd_addr;
  logic              o_rd_en;
  logic signed [7:0] i_rd_data;
  logic              o_w_valid;
  logic              i_w_ready;
  logic signed [7:0] o_w_data;
  logic [6:0]        o_w_post_idx;
  logic              o_w_last;
  logic              o_busy, o_done, o_err;

  synapse_fetch_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_PRE(NPRE), .N_POST(NPOST),
    .RD_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_spike_valid(i_spike_valid), .i_spike_idx(i_spike_idx),
    .o_spike_ready(o_spike_ready), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en),
    .i_rd_data(i_rd_data), .o_w_valid(o_w_valid), .i_w_ready(i_w_ready),
    .o_w_data(o_w_data), .o_w_post_idx(o_w_post_idx), .o_w_last(o_w_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    logic [15:0] t;
    t = {2'b00, a} * 16'd37 + 16'd11;
    return t[7:0] ^ a[12:5];
  endfunction

  // Two-cycle synapse memory model; keeps returning data regardless of reset.
  logic [7:0] mem_q1, mem_q2;
  always @(posedge clk) begin
    mem_q1 <= mem_f(o_rd_addr);
    mem_q2 <= mem_q1;
  end
  assign i_rd_data = mem_q2;

  bit rand_mode = 1'b0, ready_set = 1'b1, rnd_bit = 1'b0;
  assign i_w_ready = rand_mode ? rnd_bit : ready_set;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(posedge clk); #1; rnd_bit = 1'($urandom_range(0, 1)); end

  logic [15:0]   exp_w[$];
  logic [AW-1:0] exp_a[$];
  int n_cmp = 0, n_bad = 0;
  int issued = 0, popped = 0, rd_cnt = 0, rd_first = -1, rd_last = -1;
  int done_cnt = 0, exp_done = 0, acc_cyc = 0;
  logic [AW-1:0] last_rd_addr = '0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual event required none", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a weight.
  initial forever begin
    logic [15:0]   e;
    logic [AW-1:0] a;
    logic [7:0]    d;
    @(negedge clk);
    if (rst_n) begin
      if (o_rd_en) begin
        chk("rd_outstanding_le_depth", longint'((issued - popped + 1) <= FD), 1);
        if (exp_a.size() == 0) fail("rd_unexpected");
        else begin
          a = exp_a.pop_front();
          chk("rd_addr", o_rd_addr, a);
        end
        issued++;
        rd_cnt++;
        last_rd_addr = o_rd_addr;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
      if (o_w_valid && i_w_ready) begin
        popped++;
        if (exp_w.size() == 0) fail("w_unexpected");
        else begin
          e = exp_w.pop_front();
          d = o_w_data;
          chk("w_data", d, e[15:8]);
          chk("w_post_idx", o_w_post_idx, e[7:1]);
          chk("w_last", o_w_last, e[0]);
        end
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic push_row(input int idx);
    logic [AW-1:0] a;
    for (int p = 0; p < NPOST; p++) begin
      a = AW'(idx * NPOST + p);
      exp_a.push_back(a);
      exp_w.push_back({mem_f(a), 7'(p), (p == NPOST - 1)});
    end
    exp_done++;
    acc_cyc = cyc;
  endtask

  task automatic send_spike(input int idx);
    int n = 0;
    i_spike_valid = 1'b1;
    i_spike_idx   = 7'(idx);
    while (!o_spike_ready && n < LIMIT) begin tick; n++; end
    if (n >= LIMIT) begin
      fail("spike_accept_timeout");
    end else begin
      push_row(idx);
      tick;
    end
    i_spike_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!o_done && n < LIMIT) begin tick; n++; end
    if (n >= LIMIT) fail("done_timeout");
    else begin
      chk("queue_empty_at_done", exp_w.size(), 0);
      chk("busy_at_done", o_busy, 0);
      tick;
    end
  endtask

  task automatic flush;
    exp_w.delete();
    exp_a.delete();
    issued = 0;
    popped = 0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; i_spike_valid = 1'b0; i_spike_idx = '0;
    repeat (3) tick;
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_w_valid", o_w_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rst_n = 1'b1;
    tick;
    chk("ready_after_reset", o_spike_ready, 1);

    // Row 3 at full rate: latency, contiguous addresses, single done.
    rd_first = -1;
    send_spike(3);
    n = 0;
    while (!o_w_valid && n < LIMIT) begin tick; n++; end
    chk("first_valid_latency", cyc - acc_cyc, RL + 2);
    wait_done;
    chk("row3_issue_span", rd_last - rd_first, NPOST - 1);
    chk("row3_last_addr", last_rd_addr, 399);

    // Row 3 with a 20-cycle downstream stall.
    ready_set = 1'b0;
    rd_cnt = 0;
    send_spike(3);
    repeat (19) tick;
    chk("stall_reads_issued", rd_cnt, FD);
    chk("stall_w_valid", o_w_valid, 1);
    chk("stall_head_post_idx", o_w_post_idx, 0);
    chk("stall_head_data", 8'(o_w_data), mem_f(14'd300));
    ready_set = 1'b1;
    wait_done;

    // Random downstream readiness over the first and last rows.
    rand_mode = 1'b1;
    send_spike(0);
    wait_done;
    send_spike(99);
    wait_done;
    rand_mode = 1'b0;
    chk("row99_last_addr", last_rd_addr, 9999);

    // Out-of-range index.
    rd_cnt = 0;
    i_spike_valid = 1'b1;
    i_spike_idx   = 7'd100;
    tick;
    i_spike_valid = 1'b0;
    chk("bad_idx_err_pulse", o_err, 1);
    chk("bad_idx_ready", o_spike_ready, 1);
    chk("bad_idx_busy", o_busy, 0);
    tick;
    chk("bad_idx_err_one_cycle", o_err, 0);
    repeat (5) tick;
    chk("bad_idx_no_reads", rd_cnt, 0);
    chk("bad_idx_still_ready", o_spike_ready, 1);

    // Reset in the middle of a row, then a clean restart.
    send_spike(3);
    n = 0;
    while (!(o_w_valid && o_w_post_idx == 7'd50) && n < LIMIT) begin tick; n++; end
    if (n >= LIMIT) fail("post50_timeout");
    rst_n = 1'b0;
    tick;
    chk("midrow_rst_rd_addr", o_rd_addr, 0);
    chk("midrow_rst_busy", o_busy, 0);
    rst_n = 1'b1;
    flush;
    exp_done--;
    repeat (6) tick;
    chk("midrow_no_stale_valid", o_w_valid, 0);
    send_spike(7);
    wait_done;

    // Spike held valid across two rows: second accept lands on the done cycle.
    i_spike_valid = 1'b1;
    i_spike_idx   = 7'd5;
    push_row(5);
    tick;
    i_spike_idx = 7'd6;
    n = 0;
    while (!o_spike_ready && n < LIMIT) begin tick; n++; end
    chk("held_accept_on_done", o_done, 1);
    push_row(6);
    tick;
    i_spike_valid = 1'b0;
    wait_done;

    repeat (4) tick;
    chk("done_pulse_count", done_cnt, exp_done);
    chk("all_reads_consumed", exp_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end
endmodule
